gray_updown_counter: RTL and testbench

//   Parametrised up/down counter.

---
 rtl/gray_updown_counter.sv | 104 ++++++++++
 tb/tb_gray_updown_counter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/gray_updown_counter.sv
// gray_updown_counter
//   Up/down counter that keeps its state in binary and presents registered
//   binary and Gray-code views. Both views update on the same clock edge. The
//   Gray view is a register of its own, so it is glitch-free and can be used
//   as a pointer or sequence source that crosses clock domains.
//
// Parameters
//   WIDTH    counter width in bits (>= 2)
//   WRAP     1: wrap at the limits, 0: saturate at the limits
//   RST_VAL  binary reset value
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          count enable, one step per cycle
//   up_dn       1: count up, 0: count down
//   load        synchronous load of load_val (takes priority over en)
//   load_gray   1: load_val is Gray coded, 0: load_val is binary
//   load_val    value to load
//   count_bin   registered binary count
//   count_gray  registered Gray count, always bin2gray(count_bin)
//   tc          terminal count for the current direction (combinational)
//   ovf         one-cycle flag for a wrap or an attempted overrun
module gray_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int WRAP    = 1,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic             load_gray,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_bin,
  output logic [WIDTH-1:0] count_gray,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX     = '1;
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] RST_BIN = WIDTH'(RST_VAL);

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] next_bin;
  logic             next_ovf;

  // Next-state selection: load > en > hold
  always_comb begin
    next_bin = count_bin;
    next_ovf = 1'b0;
    if (load) begin
      next_bin = load_gray ? gray2bin(load_val) : load_val;
    end else if (en) begin
      if (up_dn) begin
        if (count_bin != MAX) begin
          next_bin = count_bin + ONE;
        end else begin
          next_ovf = 1'b1;
          if (WRAP != 0) next_bin = ZERO;
        end
      end else begin
        if (count_bin != ZERO) begin
          next_bin = count_bin - ONE;
        end else begin
          next_ovf = 1'b1;
          if (WRAP != 0) next_bin = MAX;
        end
      end
    end
  end

  // Output registers: the Gray view is encoded from next_bin before the
  // register so count_gray never passes through decode logic on its way out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_bin  <= RST_BIN;
      count_gray <= bin2gray(RST_BIN);
      ovf        <= 1'b0;
    end else begin
      count_bin  <= next_bin;
      count_gray <= bin2gray(next_bin);
      ovf        <= next_ovf;
    end
  end

  assign tc = (up_dn & (count_bin == MAX)) | (~up_dn & (count_bin == ZERO));

endmodule

// File: tb/tb_gray_updown_counter.sv
// tb_gray_updown_counter
//   Directed bench for gray_updown_counter. Three instances share one set of
//   inputs: the default build (wrap, reset to 0), a saturating build and a
//   build that resets to 5.
module tb_gray_updown_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up_dn;
  logic       load;
  logic       load_gray;
  logic [3:0] load_val;

  logic [3:0] bin_w, gray_w;
  logic       tc_w, ovf_w;
  logic [3:0] bin_s, gray_s;
  logic       tc_s, ovf_s;
  logic [3:0] bin_r, gray_r;
  logic       tc_r, ovf_r;

  int checks = 0;
  int errors = 0;

  gray_updown_counter #(.WIDTH(4), .WRAP(1), .RST_VAL(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_gray(load_gray), .load_val(load_val),
    .count_bin(bin_w), .count_gray(gray_w), .tc(tc_w), .ovf(ovf_w)
  );

  gray_updown_counter #(.WIDTH(4), .WRAP(0), .RST_VAL(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_gray(load_gray), .load_val(load_val),
    .count_bin(bin_s), .count_gray(gray_s), .tc(tc_s), .ovf(ovf_s)
  );

  gray_updown_counter #(.WIDTH(4), .WRAP(1), .RST_VAL(5)) dut_r5 (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_gray(load_gray), .load_val(load_val),
    .count_bin(bin_r), .count_gray(gray_r), .tc(tc_r), .ovf(ovf_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle on the falling edge before sampling.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] e;
  logic [3:0] eg;
  logic [3:0] prev_g;

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    up_dn     = 1'b0;
    load      = 1'b0;
    load_gray = 1'b0;
    load_val  = 4'b0000;

    // Reset values
    tick();
    tick();
    chk4("rst_bin", bin_w, 4'b0000);
    chk4("rst_gray", gray_w, 4'b0000);
    chk1("rst_ovf", ovf_w, 1'b0);
    chk1("rst_tc", tc_w, 1'b1);
    chk4("rst5_bin", bin_r, 4'b0101);
    chk4("rst5_gray", gray_r, 4'b0111);

    // Release and count up through a full wrap
    rst_n = 1'b1;
    tick();
    chk4("hold_bin", bin_w, 4'b0000);
    en    = 1'b1;
    up_dn = 1'b1;
    prev_g = gray_w;
    for (int i = 1; i <= 16; i++) begin
      tick();
      e  = 4'(i);
      eg = e ^ (e >> 1);
      chk4("up_bin", bin_w, e);
      chk4("up_gray", gray_w, eg);
      chk1("up_hamming", ($countones(gray_w ^ prev_g) == 1), 1'b1);
      chk1("up_ovf", ovf_w, (i == 16));
      chk1("up_tc", tc_w, (e == 4'b1111));
      prev_g = gray_w;
    end
    en = 1'b0;
    tick();
    chk1("up_ovf_drop", ovf_w, 1'b0);
    chk4("up_hold_bin", bin_w, 4'b0000);

    // Gray load beats en, then binary load
    load      = 1'b1;
    load_gray = 1'b1;
    load_val  = 4'b1100;
    en        = 1'b1;
    tick();
    chk4("ldg_bin", bin_w, 4'b1000);
    chk4("ldg_gray", gray_w, 4'b1100);
    chk1("ldg_ovf", ovf_w, 1'b0);
    load_gray = 1'b0;
    load_val  = 4'b0011;
    tick();
    chk4("ldb_bin", bin_w, 4'b0011);
    chk4("ldb_gray", gray_w, 4'b0010);

    // Down wrap from zero
    load_val = 4'b0000;
    en       = 1'b0;
    tick();
    load  = 1'b0;
    up_dn = 1'b0;
    #1;
    chk1("dn_tc_at0", tc_w, 1'b1);
    up_dn = 1'b1;
    #1;
    chk1("up_tc_at0", tc_w, 1'b0);
    up_dn = 1'b0;
    en    = 1'b1;
    tick();
    chk4("dnw_bin", bin_w, 4'b1111);
    chk4("dnw_gray", gray_w, 4'b1000);
    chk1("dnw_ovf", ovf_w, 1'b1);
    chk4("dns_bin", bin_s, 4'b0000);
    chk1("dns_ovf", ovf_s, 1'b1);
    tick();
    chk4("dnw2_bin", bin_w, 4'b1110);
    chk4("dnw2_gray", gray_w, 4'b1001);
    chk1("dnw2_ovf", ovf_w, 1'b0);

    // Saturate at MAX in the WRAP=0 build
    en       = 1'b0;
    load     = 1'b1;
    load_val = 4'b1111;
    tick();
    load  = 1'b0;
    en    = 1'b1;
    up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk4("sat_bin", bin_s, 4'b1111);
      chk4("sat_gray", gray_s, 4'b1000);
      chk1("sat_ovf", ovf_s, 1'b1);
      chk1("sat_tc", tc_s, 1'b1);
    end
    chk4("satw_bin", bin_w, 4'b0010);
    up_dn = 1'b0;
    tick();
    chk4("sat_dn_bin", bin_s, 4'b1110);
    chk1("sat_dn_ovf", ovf_s, 1'b0);

    // Asynchronous reset between edges
    en       = 1'b0;
    load     = 1'b1;
    load_val = 4'b0110;
    tick();
    load  = 1'b0;
    en    = 1'b1;
    up_dn = 1'b1;
    chk4("pre_arst_bin", bin_w, 4'b0110);
    #2;
    rst_n = 1'b0;
    #1;
    chk4("arst_bin", bin_w, 4'b0000);
    chk4("arst_gray", gray_w, 4'b0000);
    chk1("arst_ovf", ovf_w, 1'b0);
    chk4("arst5_bin", bin_r, 4'b0101);
    tick();
    chk4("arst_hold_bin", bin_w, 4'b0000);
    rst_n = 1'b1;
    tick();
    chk4("resume_bin", bin_w, 4'b0001);
    chk4("resume_gray", gray_w, 4'b0001);
    tick();
    chk4("resume2_gray", gray_w, 4'b0011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
